mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 175 +++++++++++++++++
 tb/tb_mem_access.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Data-memory access stage: issues one request per load/store, stalls the pipeline
// until ack or timeout, and forwards results to the MEM/WB register.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_memRead_i,
  input  logic        ex_memWrite_i,
  input  logic [15:0] ex_aluResult_i,
  input  logic [15:0] ex_storeData_i,
  input  logic [2:0]  ex_reg3_i,
  input  logic        ex_regWrite_i,
  input  logic        ex_resultOrMem_i,
  input  logic [15:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [15:0] dmem_addr_o,
  output logic [15:0] dmem_wdata_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [15:0] mem_memData_o,
  output logic [15:0] mem_aluResult_o,
  output logic [2:0]  mem_reg3_o,
  output logic        mem_regWrite_o,
  output logic        mem_resultOrMem_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             abort_q, abort_d;

  logic op_present_s;
  logic op_conflict_s;

  assign op_present_s  = ex_memRead_i ^ ex_memWrite_i;
  assign op_conflict_s = ex_memRead_i & ex_memWrite_i;

  // State and latched-transaction registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic; the timeout abort leaves zero data and raises the abort flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (op_present_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          addr_d  = ex_aluResult_i;
          wdata_d = ex_storeData_i;
          we_d    = ex_memWrite_i;
          abort_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          rdata_d = we_q ? 16'h0000 : dmem_rdata_i;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 16'h0000;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
    endcase
  end

  // Output decode; every output is held low while reset is asserted
  always_comb begin
    dmem_req_o        = 1'b0;
    dmem_we_o         = 1'b0;
    dmem_addr_o       = 16'h0000;
    dmem_wdata_o      = 16'h0000;
    stallreq_o        = 1'b0;
    err_o             = 1'b0;
    mem_memData_o     = 16'h0000;
    mem_aluResult_o   = 16'h0000;
    mem_reg3_o        = 3'd0;
    mem_regWrite_o    = 1'b0;
    mem_resultOrMem_o = 1'b0;
    if (!rst_i) begin
      dmem_req_o        = (state_q == S_WAIT);
      dmem_we_o         = we_q;
      dmem_addr_o       = addr_q;
      dmem_wdata_o      = wdata_q;
      mem_aluResult_o   = ex_aluResult_i;
      mem_reg3_o        = ex_reg3_i;
      mem_resultOrMem_o = ex_resultOrMem_i;
      mem_regWrite_o    = ex_regWrite_i;
      case (state_q)
        S_IDLE: begin
          stallreq_o = op_present_s;
          if (op_conflict_s) begin
            err_o          = 1'b1;
            mem_regWrite_o = 1'b0;
          end else begin
            err_o = 1'b0;
          end
        end
        S_WAIT: begin
          stallreq_o = 1'b1;
        end
        S_DONE: begin
          mem_memData_o = rdata_q;
          if (abort_q) begin
            err_o          = 1'b1;
            mem_regWrite_o = 1'b0;
          end else begin
            err_o = 1'b0;
          end
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end else begin
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a per-cycle vector table plus hand-written
// timeout and mid-access reset sequences.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_memRead_i, ex_memWrite_i;
  logic [15:0] ex_aluResult_i, ex_storeData_i;
  logic [2:0]  ex_reg3_i;
  logic        ex_regWrite_i, ex_resultOrMem_i;
  logic [15:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        dmem_req_o, dmem_we_o;
  logic [15:0] dmem_addr_o, dmem_wdata_o;
  logic        stallreq_o, err_o;
  logic [15:0] mem_memData_o, mem_aluResult_o;
  logic [2:0]  mem_reg3_o;
  logic        mem_regWrite_o, mem_resultOrMem_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_access dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_memRead_i(ex_memRead_i), .ex_memWrite_i(ex_memWrite_i),
    .ex_aluResult_i(ex_aluResult_i), .ex_storeData_i(ex_storeData_i),
    .ex_reg3_i(ex_reg3_i), .ex_regWrite_i(ex_regWrite_i),
    .ex_resultOrMem_i(ex_resultOrMem_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .stallreq_o(stallreq_o), .err_o(err_o),
    .mem_memData_o(mem_memData_o), .mem_aluResult_o(mem_aluResult_o),
    .mem_reg3_o(mem_reg3_o), .mem_regWrite_o(mem_regWrite_o),
    .mem_resultOrMem_o(mem_resultOrMem_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd, wr;
    logic [15:0] alu, sd;
    logic [2:0]  r3;
    logic        rw, rom;
    logic [15:0] rdata;
    logic        ack;
    logic        e_req, e_we;
    logic [15:0] e_addr, e_wdata;
    logic        e_stall, e_err;
    logic [15:0] e_mdata;
    logic        e_regw;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [15:0] alu, input logic [15:0] sd,
    input logic [2:0] r3, input logic rw, input logic rom, input logic [15:0] rdata,
    input logic ack, input logic e_req, input logic e_we, input logic [15:0] e_addr,
    input logic [15:0] e_wdata, input logic e_stall, input logic e_err,
    input logic [15:0] e_mdata, input logic e_regw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.alu = alu; v.sd = sd; v.r3 = r3; v.rw = rw; v.rom = rom;
    v.rdata = rdata; v.ack = ack; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_stall = e_stall; v.e_err = e_err; v.e_mdata = e_mdata;
    v.e_regw = e_regw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [2:0] r3, input logic rw,
                       input logic rom, input logic [15:0] rdata, input logic ack);
    ex_memRead_i = rd; ex_memWrite_i = wr; ex_aluResult_i = alu; ex_storeData_i = sd;
    ex_reg3_i = r3; ex_regWrite_i = rw; ex_resultOrMem_i = rom;
    dmem_rdata_i = rdata; dmem_ack_i = ack;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 16'(dmem_req_o), 16'h0000);
    chk({tag, "_we"}, 16'(dmem_we_o), 16'h0000);
    chk({tag, "_addr"}, dmem_addr_o, 16'h0000);
    chk({tag, "_wdata"}, dmem_wdata_o, 16'h0000);
    chk({tag, "_stall"}, 16'(stallreq_o), 16'h0000);
    chk({tag, "_err"}, 16'(err_o), 16'h0000);
    chk({tag, "_mdata"}, mem_memData_o, 16'h0000);
    chk({tag, "_alu"}, mem_aluResult_o, 16'h0000);
    chk({tag, "_reg3"}, 16'(mem_reg3_o), 16'h0000);
    chk({tag, "_regw"}, 16'(mem_regWrite_o), 16'h0000);
    chk({tag, "_rom"}, 16'(mem_resultOrMem_o), 16'h0000);
  endtask

  initial begin
    //            rd wr alu       sd        r3 rw rom rdata     ack | req we addr     wdata     st er mdata     regw
    vecs[0]  = mk(1, 0, 16'h0040, 16'h0000, 2, 1, 1, 16'h0000, 0,   0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);
    vecs[1]  = mk(1, 0, 16'h0040, 16'h0000, 2, 1, 1, 16'h0000, 0,   1, 0, 16'h0040, 16'h0000, 1, 0, 16'h0000, 1);
    vecs[2]  = mk(1, 0, 16'h0040, 16'h0000, 2, 1, 1, 16'hBEEF, 1,   1, 0, 16'h0040, 16'h0000, 1, 0, 16'h0000, 1);
    vecs[3]  = mk(1, 0, 16'h0040, 16'h0000, 2, 1, 1, 16'h0000, 0,   0, 0, 16'h0040, 16'h0000, 0, 0, 16'hBEEF, 1);
    vecs[4]  = mk(0, 0, 16'h00FF, 16'h0000, 5, 1, 0, 16'h1111, 1,   0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[5]  = mk(0, 0, 16'h0033, 16'h0000, 1, 0, 0, 16'h0000, 0,   0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[6]  = mk(0, 1, 16'h0010, 16'h1234, 0, 0, 0, 16'h0000, 0,   0, 0, 16'h0040, 16'h0000, 1, 0, 16'h0000, 0);
    vecs[7]  = mk(0, 1, 16'h0010, 16'h1234, 0, 0, 0, 16'h7777, 1,   1, 1, 16'h0010, 16'h1234, 1, 0, 16'h0000, 0);
    vecs[8]  = mk(0, 1, 16'h0010, 16'h1234, 0, 0, 0, 16'h0000, 0,   0, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0);
    vecs[9]  = mk(1, 0, 16'h0100, 16'h0000, 3, 1, 1, 16'h0000, 0,   0, 1, 16'h0010, 16'h1234, 1, 0, 16'h0000, 1);
    vecs[10] = mk(1, 0, 16'h0100, 16'h0000, 3, 1, 1, 16'h5A5A, 1,   1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0000, 1);
    vecs[11] = mk(1, 0, 16'h0100, 16'h0000, 3, 1, 1, 16'h0000, 0,   0, 0, 16'h0100, 16'h0000, 0, 0, 16'h5A5A, 1);
    vecs[12] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0,   0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[13] = mk(1, 1, 16'h0200, 16'hABCD, 4, 1, 1, 16'h0000, 0,   0, 0, 16'h0100, 16'h0000, 0, 1, 16'h0000, 0);
    vecs[14] = mk(0, 0, 16'h0200, 16'h0000, 4, 1, 0, 16'h0000, 0,   0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1);

    // Reset with live inputs: everything, pass-through included, must read 0
    rst_i = 1'b1;
    drive(1, 0, 16'hFFFF, 16'hFFFF, 3'd7, 1, 1, 16'hFFFF, 1);
    #12;
    chk_zero("rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 16'h0000, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].sd, vecs[i].r3,
            vecs[i].rw, vecs[i].rom, vecs[i].rdata, vecs[i].ack);
      #2;
      chk($sformatf("v%0d_req", i), 16'(dmem_req_o), 16'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i), 16'(dmem_we_o), 16'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), dmem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), dmem_wdata_o, vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), 16'(stallreq_o), 16'(vecs[i].e_stall));
      chk($sformatf("v%0d_err", i), 16'(err_o), 16'(vecs[i].e_err));
      chk($sformatf("v%0d_mdata", i), mem_memData_o, vecs[i].e_mdata);
      chk($sformatf("v%0d_regw", i), 16'(mem_regWrite_o), 16'(vecs[i].e_regw));
      chk($sformatf("v%0d_alu", i), mem_aluResult_o, vecs[i].alu);
      chk($sformatf("v%0d_reg3", i), 16'(mem_reg3_o), 16'(vecs[i].r3));
      chk($sformatf("v%0d_rom", i), 16'(mem_resultOrMem_o), 16'(vecs[i].rom));
    end

    // Load with no ack: 15 request cycles, then an aborting DONE
    @(negedge clk_i);
    drive(1, 0, 16'h0222, 16'h0000, 3'd6, 1, 1, 16'h0000, 0);
    #2;
    chk("to_idle_stall", 16'(stallreq_o), 16'h0001);
    chk("to_idle_req", 16'(dmem_req_o), 16'h0000);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      #2;
      chk($sformatf("to_w%0d_req", i), 16'(dmem_req_o), 16'h0001);
      chk($sformatf("to_w%0d_err", i), 16'(err_o), 16'h0000);
      chk($sformatf("to_w%0d_addr", i), dmem_addr_o, 16'h0222);
      chk($sformatf("to_w%0d_stall", i), 16'(stallreq_o), 16'h0001);
    end
    @(negedge clk_i);
    #2;
    chk("to_done_req", 16'(dmem_req_o), 16'h0000);
    chk("to_done_err", 16'(err_o), 16'h0001);
    chk("to_done_regw", 16'(mem_regWrite_o), 16'h0000);
    chk("to_done_mdata", mem_memData_o, 16'h0000);
    chk("to_done_stall", 16'(stallreq_o), 16'h0000);
    @(negedge clk_i);
    drive(0, 0, 16'h0000, 16'h0000, 3'd0, 1, 0, 16'h0000, 0);
    #2;
    chk("to_after_err", 16'(err_o), 16'h0000);
    chk("to_after_req", 16'(dmem_req_o), 16'h0000);
    chk("to_after_regw", 16'(mem_regWrite_o), 16'h0001);

    // Reset during the third WAIT cycle, then a late ack that must be ignored
    @(negedge clk_i);
    drive(1, 0, 16'h0300, 16'h0000, 3'd1, 1, 1, 16'h0000, 0);
    #2;
    chk("rw_idle_stall", 16'(stallreq_o), 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #2;
      chk($sformatf("rw_w%0d_req", i), 16'(dmem_req_o), 16'h0001);
    end
    #1;
    rst_i = 1'b1;
    #1;
    chk_zero("rw_async");
    @(posedge clk_i);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 16'hFFFF;
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 16'hFFFF, 1);
    #2;
    chk("rw_post_req", 16'(dmem_req_o), 16'h0000);
    chk("rw_post_stall", 16'(stallreq_o), 16'h0000);
    chk("rw_post_addr", dmem_addr_o, 16'h0000);
    chk("rw_post_mdata", mem_memData_o, 16'h0000);
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    #2;
    chk("rw_late_req", 16'(dmem_req_o), 16'h0000);
    chk("rw_late_mdata", mem_memData_o, 16'h0000);
    chk("rw_late_err", 16'(err_o), 16'h0000);
    chk("rw_late_stall", 16'(stallreq_o), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
